// File: rtl/cp0_ctrl_v2.sv
// Coprocessor-0 at the commit boundary: CP0 registers, exception/interrupt arbitration, ERET and Count/Compare timer.
// Define CP0_PRID_CONFIG_EN to expose read-only PRId (reg 15) and Config (reg 16).
module cp0_ctrl_v2 #(
  parameter int          HW_INT_NUM   = 6,
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  commit_valid_i,
  input  logic [31:0]           pc_i,
  input  logic                  in_delayslot_i,
  input  logic [7:0]            exc_type_i,
  input  logic [31:0]           bad_addr_i,
  input  logic [HW_INT_NUM-1:0] hw_int_i,
  input  logic                  we_i,
  input  logic [4:0]            wr_addr_i,
  input  logic [31:0]           wr_data_i,
  input  logic [4:0]            rd_addr_i,
  output logic [31:0]           rd_data_o,
  output logic                  flush_o,
  output logic [31:0]           target_pc_o,
  output logic                  timer_int_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
`ifdef CP0_PRID_CONFIG_EN
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;
`endif

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [4:0]  PRESC_MAX    = 5'(COUNT_DIV - 1);

  logic [31:0] status_reg, epc_reg, badvaddr_reg, count_reg, compare_reg;
  logic [31:0] target_reg;
  logic        bd_reg, ti_reg, flush_reg;
  logic [4:0]  exccode_reg;
  logic [1:0]  sw_ip_reg;
  logic [5:0]  hw_ip_reg;
  logic [4:0]  presc_reg;

  logic [5:0]  hw_int_ext;
  logic [7:0]  ip;
  logic [31:0] cause_val, status_wr, cause_wr, rd_cur;
  logic        int_pending, exc_take, eret_take, event_take, wr_ok;
  logic        bad_we, presc_wrap, count_wr, compare_wr;
  logic [4:0]  exc_code;
  logic [31:0] bad_val, count_inc;

  // Unused interrupt lines are tied low so the upper IP bits read 0.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_hw_int
      if (gi < HW_INT_NUM) begin : g_used
        assign hw_int_ext[gi] = hw_int_i[gi];
      end else begin : g_unused
        assign hw_int_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign ip        = {hw_ip_reg[5] | ti_reg, hw_ip_reg[4:0], sw_ip_reg};
  assign cause_val = {bd_reg, ti_reg, 14'd0, ip, 1'b0, exccode_reg, 2'b00};
  assign status_wr = (status_reg & ~STATUS_WMASK) | (wr_data_i & STATUS_WMASK);
  assign cause_wr  = {cause_val[31:10], wr_data_i[9:8], cause_val[7:0]};

  assign int_pending = (|(ip & status_reg[15:8])) && status_reg[0] && !status_reg[1];

  always_comb begin
    exc_take  = 1'b0;
    eret_take = 1'b0;
    exc_code  = EXC_INT;
    bad_we    = 1'b0;
    bad_val   = 32'd0;
    if (commit_valid_i) begin
      if (int_pending) begin
        exc_take = 1'b1;
      end else if (exc_type_i[7]) begin
        exc_take = 1'b1; exc_code = EXC_ADEL; bad_we = 1'b1; bad_val = pc_i;
      end else if (exc_type_i[6]) begin
        exc_take = 1'b1; exc_code = EXC_RI;
      end else if (exc_type_i[5]) begin
        exc_take = 1'b1; exc_code = EXC_OV;
      end else if (exc_type_i[4]) begin
        exc_take = 1'b1; exc_code = EXC_BP;
      end else if (exc_type_i[3]) begin
        exc_take = 1'b1; exc_code = EXC_SYS;
      end else if (exc_type_i[2]) begin
        exc_take = 1'b1; exc_code = EXC_ADEL; bad_we = 1'b1; bad_val = bad_addr_i;
      end else if (exc_type_i[1]) begin
        exc_take = 1'b1; exc_code = EXC_ADES; bad_we = 1'b1; bad_val = bad_addr_i;
      end else if (exc_type_i[0]) begin
        eret_take = 1'b1;
      end
    end
  end

  // A taken event discards the MTC0 of the same cycle, side effects included.
  assign event_take = exc_take | eret_take;
  assign wr_ok      = we_i && !event_take;
  assign count_wr   = wr_ok && (wr_addr_i == REG_COUNT);
  assign compare_wr = wr_ok && (wr_addr_i == REG_COMPARE);
  assign presc_wrap = (presc_reg == PRESC_MAX);
  assign count_inc  = count_reg + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      status_reg   <= STATUS_RESET;
      epc_reg      <= 32'd0;
      badvaddr_reg <= 32'd0;
      count_reg    <= 32'd0;
      compare_reg  <= 32'd0;
      target_reg   <= 32'd0;
      bd_reg       <= 1'b0;
      ti_reg       <= 1'b0;
      flush_reg    <= 1'b0;
      exccode_reg  <= 5'd0;
      sw_ip_reg    <= 2'd0;
      hw_ip_reg    <= 6'd0;
      presc_reg    <= 5'd0;
    end else begin
      hw_ip_reg <= hw_int_ext;
      flush_reg <= event_take;
      if (exc_take)       target_reg <= EXC_VECTOR;
      else if (eret_take) target_reg <= epc_reg;

      if (count_wr) begin
        count_reg <= wr_data_i;
        presc_reg <= 5'd0;
      end else if (presc_wrap) begin
        count_reg <= count_inc;
        presc_reg <= 5'd0;
      end else begin
        presc_reg <= presc_reg + 5'd1;
      end

      if (compare_wr) begin
        compare_reg <= wr_data_i;
        ti_reg      <= 1'b0;
      end else if (!count_wr && presc_wrap && (count_inc == compare_reg)) begin
        ti_reg <= 1'b1;
      end

      if (exc_take)       status_reg[1] <= 1'b1;
      else if (eret_take) status_reg[1] <= 1'b0;
      else if (wr_ok && wr_addr_i == REG_STATUS) status_reg <= status_wr;

      // Nested exceptions keep the original EPC/BD so the outer handler can still return.
      if (exc_take) begin
        exccode_reg <= exc_code;
        if (!status_reg[1]) begin
          bd_reg  <= in_delayslot_i;
          epc_reg <= in_delayslot_i ? pc_i - 32'd4 : pc_i;
        end
      end else if (wr_ok && wr_addr_i == REG_CAUSE) begin
        sw_ip_reg <= wr_data_i[9:8];
      end else if (wr_ok && wr_addr_i == REG_EPC) begin
        epc_reg <= wr_data_i;
      end

      if (bad_we) badvaddr_reg <= bad_val;
    end
  end

  always_comb begin
    rd_cur = 32'd0;
    case (rd_addr_i)
      REG_BADVADDR: rd_cur = badvaddr_reg;
      REG_COUNT:    rd_cur = count_reg;
      REG_COMPARE:  rd_cur = compare_reg;
      REG_STATUS:   rd_cur = status_reg;
      REG_CAUSE:    rd_cur = cause_val;
      REG_EPC:      rd_cur = epc_reg;
`ifdef CP0_PRID_CONFIG_EN
      REG_PRID:     rd_cur = 32'h0000_4220;
      REG_CONFIG:   rd_cur = 32'h8000_0000;
`endif
      default:      rd_cur = 32'd0;
    endcase
    rd_data_o = rd_cur;
    // Bypass shows the value the accepted write will leave behind.
    if (wr_ok && (wr_addr_i == rd_addr_i)) begin
      case (rd_addr_i)
        REG_COUNT, REG_COMPARE, REG_EPC: rd_data_o = wr_data_i;
        REG_STATUS:                      rd_data_o = status_wr;
        REG_CAUSE:                       rd_data_o = cause_wr;
        default:                         rd_data_o = rd_cur;
      endcase
    end
  end

  assign flush_o     = flush_reg;
  assign target_pc_o = target_reg;
  assign timer_int_o = ti_reg;
  assign status_o    = status_reg;
  assign cause_o     = cause_val;
  assign epc_o       = epc_reg;

endmodule

// File: doc/cp0_ctrl_v2.md
Name: cp0_ctrl_v2

Overview:
- Parametrised second-generation coprocessor-0 block: architectural CP0 registers, exception/interrupt arbitration, ERET handling and count/compare timer.
- Sits at the commit (MEM/WB) boundary of the pipeline.
- Arbitrates one committing instruction per cycle.
- Produces a registered one-cycle flush pulse plus redirect PC to fetch.
- Extends the previous CP0 with configurable interrupt width, programmable exception vector, count prescaler, explicit commit qualification and Status.IE gating.

Parameters:
- HW_INT_NUM, 6: hardware interrupt lines, 1..6; mapped to Cause.IP[2+HW_INT_NUM-1:2], unused IP bits read 0.
- EXC_VECTOR, 32'hBFC0_0380: redirect target for every exception and interrupt.
- COUNT_DIV, 2: Count increments once every COUNT_DIV clocks, 1..16.
- STATUS_RESET, 32'h0040_0000: Status value after reset (BEV=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- commit_valid_i  in  1  instruction at commit is valid; all exception inputs ignored when 0
- pc_i  in  32  PC of committing instruction
- in_delayslot_i  in  1  committing instruction is in a branch delay slot
- exc_type_i  in  8  [7] fetch AdEL, [6] RI, [5] Ov, [4] Bp, [3] Sys, [2] data AdEL, [1] AdES, [0] ERET
- bad_addr_i  in  32  faulting data address (used for [2],[1])
- hw_int_i  in  HW_INT_NUM  level-sensitive external interrupts
- we_i  in  1  MTC0 write enable
- wr_addr_i  in  5  MTC0 register number
- wr_data_i  in  32  MTC0 data
- rd_addr_i  in  5  MFC0 register number
- rd_data_o  out  32  MFC0 read data (combinational)
- flush_o  out  1  registered one-cycle pipeline flush
- target_pc_o  out  32  redirect PC, valid while flush_o=1
- timer_int_o  out  1  Cause.TI
- status_o  out  32  current Status
- cause_o  out  32  current Cause
- epc_o  out  32  current EPC

Behaviour:
- Reset:
  - Status=STATUS_RESET; Cause, EPC, BadVAddr, Count, Compare=0.
  - Prescaler=0; flush_o=0; target_pc_o=0; timer_int_o=0.
- Registers (others read 0, writes ignored):
  - 8 BadVAddr RO
  - 9 Count RW
  - 11 Compare RW
  - 12 Status: writable [15:8] IM, [1] EXL, [0] IE
  - 13 Cause: writable [9:8] only
  - 14 EPC RW
- Cause fields:
  - Cause.IP[7:2] resampled from hw_int_i every clock.
  - IP[7] = hw_int_i[5] (if present) OR TI.
- Read bypass: when we_i and wr_addr_i==rd_addr_i, rd_data_o returns the post-write value with write masks applied.
- Timer:
  - Prescaler counts 0..COUNT_DIV-1; Count increments on wrap, 32-bit wrap-around.
  - TI set when Count==Compare after increment; sticky.
  - MTC0 Compare clears TI. MTC0 Count resets prescaler to 0.
- Interrupt pending: (Cause.IP & Status.IM)!=0 && IE==1 && EXL==0 && commit_valid_i.
- Arbitration priority (one event per cycle): interrupt > [7] > [6] > [5] > [4] > [3] > [2] > [1] > ERET [0].
- Exception entry, evaluated at posedge:
  - If EXL==0: EPC=in_delayslot_i ? pc_i-4 : pc_i; Cause.BD=in_delayslot_i.
  - If EXL==1: EPC and BD unchanged.
  - Cause.ExcCode: Int=0, AdEL=4, AdES=5, Sys=8, Bp=9, RI=10, Ov=12.
  - EXL=1.
  - BadVAddr=pc_i for [7], bad_addr_i for [2]/[1].
  - flush_o=1, target_pc_o=EXC_VECTOR next cycle.
- ERET: EXL=0; flush_o=1, target_pc_o=EPC (value before this cycle's update) next cycle.
- flush_o is high exactly one cycle after the event; low otherwise. Back-to-back events produce back-to-back pulses.
- Simultaneous MTC0 and taken event in the same cycle: event wins; MTC0 discarded entirely (including Compare/TI side effects).
- Timer increment and MTC0 Count in the same cycle: written value wins.
- Reset mid-flush: flush_o=0 next cycle.

Optional Feature:
- CP0_PRID_CONFIG_EN:
  - Defined: read-only PRId (reg 15) = 32'h0000_4220 and Config (reg 16) = 32'h8000_0000 appear; writes to them ignored.
  - Undefined: regs 15/16 read 0. No other change.

Test Plan:
- Reset then read regs 8..14 -> Status=32'h0040_0000, all others 0; flush_o=0.
- COUNT_DIV=2, Compare=5, IM[7]=1, IE=1 -> Count reaches 5 after 10 clocks; TI=1. Next valid commit pc_i=32'h8000_0100 -> flush_o pulse, target_pc_o=32'hBFC0_0380, EPC=32'h8000_0100, ExcCode=0. MTC0 Compare clears TI.
- Ov and Sys both set, in_delayslot_i=1, pc_i=32'h8000_0204 -> ExcCode=12, EPC=32'h8000_0200, BD=1, EXL=1. ERET next commit -> target_pc_o=32'h8000_0200, EXL=0.
- AdES with bad_addr_i=32'h0000_0003 while EXL=1 -> BadVAddr=3, EPC unchanged, flush_o pulses.
- we_i write Status=32'hFFFF_FFFF with rd_addr_i=12 same cycle -> rd_data_o=32'h0040_FF03. Repeat with simultaneous Sys -> Status write discarded.
- hw_int_i[0]=1, IM[2]=1, IE=1, commit_valid_i=0 -> no flush. Assert commit_valid_i -> interrupt taken.
